// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: state encoding,
// vector/index sizing, dwell counter width and the first-mismatch finder.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_VEC = 8;
  localparam int IDX_W = 3;

  // Width of a counter that must hold 0..dwell-1, never narrower than one bit.
  function automatic int cnt_width(input int dwell);
    if (dwell <= 1) begin
      return 1;
    end else begin
      return $clog2(dwell);
    end
  endfunction

  // Lowest set bit position of a mismatch mask, 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] first_diff(input logic [N_VEC-1:0] diff);
    logic [IDX_W-1:0] pos;
    pos = 3'd0;
    for (int k = N_VEC - 1; k >= 0; k--) begin
      if (diff[k]) begin
        pos = IDX_W'(k);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper (slave) and its environment (master).
// The TT_CHECK_EN build adds the pass flag and first-error index.
interface truth_table_sweeper_if;

  logic                     i_start;
  logic                     i_y;
  logic                     o_a;
  logic                     o_b;
  logic                     o_c;
  logic [tt_pkg::IDX_W-1:0] o_idx;
  logic [tt_pkg::N_VEC-1:0] o_table;
  logic                     o_busy;
  logic                     o_done;
`ifdef TT_CHECK_EN
  logic                     o_pass;
  logic [tt_pkg::IDX_W-1:0] o_err_idx;

  modport slave (
    input  i_start, i_y,
    output o_a, o_b, o_c, o_idx, o_table, o_busy, o_done, o_pass, o_err_idx
  );

  modport master (
    output i_start, i_y,
    input  o_a, o_b, o_c, o_idx, o_table, o_busy, o_done, o_pass, o_err_idx
  );
`else
  modport slave (
    input  i_start, i_y,
    output o_a, o_b, o_c, o_idx, o_table, o_busy, o_done
  );

  modport master (
    output i_start, i_y,
    input  o_a, o_b, o_c, o_idx, o_table, o_busy, o_done
  );
`endif

endinterface

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Dwell timer: counts cycles while enabled and flags the last cycle of each
// DWELL-cycle hold, then wraps to zero.
module tt_dwell_timer
  import tt_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int              CNT_W    = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             last_s;

  assign last_s = (cnt_r == CNT_LAST);
  assign o_tick = i_en && last_s;

  // Dwell counter: cleared on start, wraps on the terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= CNT_W'(0);
    end else if (i_clear) begin
      cnt_r <= CNT_W'(0);
    end else if (i_en) begin
      if (last_s) begin
        cnt_r <= CNT_W'(0);
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 8 {a,b,c} vectors for DWELL cycles each and
// captures y into o_table. Define TT_CHECK_EN to add the EXPECTED compare.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int DWELL = 10
`ifdef TT_CHECK_EN
  , parameter logic [N_VEC-1:0] EXPECTED = 8'h00
`endif
) (
  input logic                  i_clk,
  input logic                  i_rst,
  truth_table_sweeper_if.slave bus
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [N_VEC-1:0] table_r;
  logic             busy_r;
  logic             done_r;
  logic             tick_s;
  logic             en_s;
  logic             start_ok_s;
  logic             last_vec_s;

  assign en_s       = (state_r == DRIVE);
  assign last_vec_s = (idx_r == IDX_W'(N_VEC - 1));

  // A start is honoured only outside an active sweep.
  always_comb begin
    start_ok_s = 1'b0;
    if (bus.i_start && (state_r != DRIVE)) begin
      start_ok_s = 1'b1;
    end else begin
      start_ok_s = 1'b0;
    end
  end

  tt_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (start_ok_s),
    .i_en    (en_s),
    .o_tick  (tick_s)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.i_start) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        if (tick_s && last_vec_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      DONE: begin
        if (bus.i_start) begin
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Vector index, captured table and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx_r   <= 3'd0;
      table_r <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.i_start) begin
            idx_r   <= 3'd0;
            table_r <= 8'h00;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            idx_r   <= 3'd0;
          end
        end
        DRIVE: begin
          if (tick_s) begin
            table_r[idx_r] <= bus.i_y;
            if (last_vec_s) begin
              idx_r  <= 3'd0;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              idx_r  <= idx_r + 3'd1;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          idx_r   <= 3'd0;
          table_r <= 8'h00;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // The vector pins are the index itself; idx is 0 outside DRIVE.
  assign bus.o_a     = idx_r[2];
  assign bus.o_b     = idx_r[1];
  assign bus.o_c     = idx_r[0];
  assign bus.o_idx   = idx_r;
  assign bus.o_table = table_r;
  assign bus.o_busy  = busy_r;
  assign bus.o_done  = done_r;

`ifdef TT_CHECK_EN
  logic [N_VEC-1:0] final_table_s;
  logic             pass_r;
  logic [IDX_W-1:0] err_idx_r;

  // The verdict is taken on the same edge that stores the last sample.
  always_comb begin
    final_table_s        = table_r;
    final_table_s[idx_r] = bus.i_y;
  end

  // Pass flag and first mismatching index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pass_r    <= 1'b0;
      err_idx_r <= 3'd0;
    end else if (start_ok_s) begin
      pass_r    <= 1'b0;
      err_idx_r <= 3'd0;
    end else if (en_s && tick_s && last_vec_s) begin
      pass_r    <= (final_table_s == EXPECTED);
      err_idx_r <= first_diff(final_table_s ^ EXPECTED);
    end else begin
      pass_r    <= pass_r;
      err_idx_r <= err_idx_r;
    end
  end

  assign bus.o_pass    = pass_r;
  assign bus.o_err_idx = err_idx_r;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (DWELL=10 and DWELL=1) checked
// every cycle against a timing model, plus directed sweeps with literal tables.
module tb_truth_table_sweeper;

  logic clk;
  int   checks;
  int   errors;
  logic cmp_en;

  int          dw [2];
  logic        start_s [2];
  logic        rst_s [2];
  logic [7:0]  func_s [2];

  logic [2:0]  d_idx [2];
  logic [7:0]  d_tbl [2];
  logic        d_a [2];
  logic        d_b [2];
  logic        d_c [2];
  logic        d_busy [2];
  logic        d_done [2];
  logic        d_pass [2];
  logic [2:0]  d_err [2];

  // Model state: sweep active, cycles elapsed since start, table, flags
  logic        m_active [2];
  int          m_k [2];
  logic [7:0]  m_table [2];
  logic        m_done [2];
  logic        m_pass [2];
  logic [2:0]  m_err [2];

  truth_table_sweeper_if bus0 ();
  truth_table_sweeper_if bus1 ();

`ifdef TT_CHECK_EN
  truth_table_sweeper #(.DWELL(10), .EXPECTED(8'h96)) dut0 (.i_clk(clk), .i_rst(rst_s[0]), .bus(bus0));
  truth_table_sweeper #(.DWELL(1),  .EXPECTED(8'h96)) dut1 (.i_clk(clk), .i_rst(rst_s[1]), .bus(bus1));
  assign d_pass[0] = bus0.o_pass;
  assign d_pass[1] = bus1.o_pass;
  assign d_err[0]  = bus0.o_err_idx;
  assign d_err[1]  = bus1.o_err_idx;
`else
  truth_table_sweeper #(.DWELL(10)) dut0 (.i_clk(clk), .i_rst(rst_s[0]), .bus(bus0));
  truth_table_sweeper #(.DWELL(1))  dut1 (.i_clk(clk), .i_rst(rst_s[1]), .bus(bus1));
  assign d_pass[0] = 1'b0;
  assign d_pass[1] = 1'b0;
  assign d_err[0]  = 3'd0;
  assign d_err[1]  = 3'd0;
`endif

  assign bus0.i_start = start_s[0];
  assign bus1.i_start = start_s[1];
  assign bus0.i_y = func_s[0][{bus0.o_a, bus0.o_b, bus0.o_c}];
  assign bus1.i_y = func_s[1][{bus1.o_a, bus1.o_b, bus1.o_c}];

  assign d_idx[0] = bus0.o_idx;   assign d_idx[1] = bus1.o_idx;
  assign d_tbl[0] = bus0.o_table; assign d_tbl[1] = bus1.o_table;
  assign d_a[0] = bus0.o_a;       assign d_a[1] = bus1.o_a;
  assign d_b[0] = bus0.o_b;       assign d_b[1] = bus1.o_b;
  assign d_c[0] = bus0.o_c;       assign d_c[1] = bus1.o_c;
  assign d_busy[0] = bus0.o_busy; assign d_busy[1] = bus1.o_busy;
  assign d_done[0] = bus0.o_done; assign d_done[1] = bus1.o_done;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, i, $time, got, exp);
    end
  endtask

  // Model: sweep position derived from cycles elapsed since the accepted start.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) begin
        m_active[i] = 1'b0; m_k[i] = 0; m_table[i] = 8'h00;
        m_done[i] = 1'b0; m_pass[i] = 1'b0; m_err[i] = 3'd0;
      end else if (m_active[i]) begin
        if ((m_k[i] % dw[i]) == dw[i] - 1)
          m_table[i][m_k[i] / dw[i]] = func_s[i][m_k[i] / dw[i]];
        m_k[i]++;
        if (m_k[i] == 8 * dw[i]) begin
          automatic logic [7:0] diff = m_table[i] ^ 8'h96;
          automatic bit found = 1'b0;
          m_active[i] = 1'b0; m_k[i] = 0; m_done[i] = 1'b1;
          m_pass[i] = (diff == 8'h00);
          m_err[i] = 3'd0;
          for (int k = 0; k < 8; k++) begin
            if (diff[k] && !found) begin
              m_err[i] = 3'(k);
              found = 1'b1;
            end
          end
        end
      end else if (start_s[i]) begin
        m_active[i] = 1'b1; m_k[i] = 0; m_table[i] = 8'h00;
        m_done[i] = 1'b0; m_pass[i] = 1'b0; m_err[i] = 3'd0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        automatic int e_idx = m_active[i] ? (m_k[i] / dw[i]) : 0;
        chk("idx", i, 32'(d_idx[i]), 32'(e_idx));
        chk("abc", i, 32'({d_a[i], d_b[i], d_c[i]}), 32'(e_idx));
        chk("table", i, 32'(d_tbl[i]), 32'(m_table[i]));
        chk("busy", i, 32'(d_busy[i]), 32'(m_active[i]));
        chk("done", i, 32'(d_done[i]), 32'(m_done[i]));
`ifdef TT_CHECK_EN
        chk("pass", i, 32'(d_pass[i]), 32'(m_pass[i]));
        chk("err_idx", i, 32'(d_err[i]), 32'(m_err[i]));
`endif
      end
    end
  end

  // One full sweep on instance i, optionally with a stray start at idx==stray.
  task automatic run_sweep(input int i, input logic [7:0] fn, input logic [7:0] exp_tbl,
                           input int stray, input logic exp_pass, input logic [2:0] exp_err);
    int n;
    bit pulsed;
    func_s[i] = fn;
    @(negedge clk); start_s[i] = 1'b1;
    @(negedge clk); start_s[i] = 1'b0;
    chk("start_busy", i, 32'(d_busy[i]), 32'd1);
    chk("start_done", i, 32'(d_done[i]), 32'd0);
    chk("start_tbl", i, 32'(d_tbl[i]), 32'h00);
    n = 0;
    pulsed = 1'b0;
    while (d_busy[i] && n < 2000) begin
      n++;
      if (stray >= 0 && !pulsed && d_idx[i] == 3'(stray)) begin
        start_s[i] = 1'b1;
        pulsed = 1'b1;
      end else begin
        start_s[i] = 1'b0;
      end
      @(negedge clk);
    end
    start_s[i] = 1'b0;
    chk("sweep_len", i, 32'(n), 32'(8 * dw[i]));
    chk("final_tbl", i, 32'(d_tbl[i]), 32'(exp_tbl));
    chk("model_tbl", i, 32'(m_table[i]), 32'(exp_tbl));
    chk("final_done", i, 32'(d_done[i]), 32'd1);
`ifdef TT_CHECK_EN
    chk("final_pass", i, 32'(d_pass[i]), 32'(exp_pass));
    chk("final_err", i, 32'(d_err[i]), 32'(exp_err));
`else
    if (exp_pass === 1'bx || exp_err === 3'bx) begin
      chk("arg", i, 32'd0, 32'd1);
    end
`endif
  endtask

  initial begin
    int n;
    clk = 1'b0;
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    dw[0] = 10;
    dw[1] = 1;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      rst_s[i] = 1'b1;
      func_s[i] = 8'h96;
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_idx", i, 32'(d_idx[i]), 32'd0);
      chk("rst_tbl", i, 32'(d_tbl[i]), 32'h00);
      chk("rst_busy", i, 32'(d_busy[i]), 32'd0);
      chk("rst_done", i, 32'(d_done[i]), 32'd0);
      rst_s[i] = 1'b0;
    end

    // XOR at DWELL=10, majority at DWELL=1
    run_sweep(0, 8'h96, 8'h96, -1, 1'b1, 3'd0);
    run_sweep(1, 8'hE8, 8'hE8, -1, 1'b0, 3'd1);
    // Stray start at idx 4 is ignored
    run_sweep(0, 8'h96, 8'h96, 4, 1'b1, 3'd0);

    // Reset while idx==3 discards the partial table
    func_s[0] = 8'h96;
    @(negedge clk); start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    n = 0;
    while (d_idx[0] != 3'd3 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("reach_idx3", 0, 32'(d_idx[0]), 32'd3);
    rst_s[0] = 1'b1;
    @(negedge clk); rst_s[0] = 1'b0;
    chk("mid_rst_idx", 0, 32'(d_idx[0]), 32'd0);
    chk("mid_rst_abc", 0, 32'({d_a[0], d_b[0], d_c[0]}), 32'd0);
    chk("mid_rst_tbl", 0, 32'(d_tbl[0]), 32'h00);
    chk("mid_rst_busy", 0, 32'(d_busy[0]), 32'd0);
    chk("mid_rst_done", 0, 32'(d_done[0]), 32'd0);
    run_sweep(0, 8'h96, 8'h96, -1, 1'b1, 3'd0);

    // Restart from DONE with constant y=1
    run_sweep(0, 8'hFF, 8'hFF, -1, 1'b0, 3'd0);
    // XOR with vector 5 faulted to 1, then healthy again
    run_sweep(0, 8'hB6, 8'hB6, -1, 1'b0, 3'd5);
    run_sweep(0, 8'h96, 8'h96, -1, 1'b1, 3'd0);

    // Random functions, starts and resets on both instances
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        start_s[i] = ($urandom_range(0, 7) == 0);
        rst_s[i] = ($urandom_range(0, 199) == 0);
        if (!m_active[i] && $urandom_range(0, 3) == 0)
          func_s[i] = 8'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      rst_s[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
